// File: rtl/sram_fifo_fwft_adapter.sv
`default_nettype none
// ============================================================================
// Module      : sram_fifo_fwft_adapter
// Description : Hides the RD_LATENCY-cycle read latency of a BRAM FIFO.
//               Pops are issued against buffer credit, returned words are
//               captured into a small circular buffer, and the head word is
//               presented as a first-word-fall-through valid/ready stream.
//               Optional macro SRAM_FWFT_STALL_CNT_EN adds stall_cnt_o, a
//               saturating count of cycles with valid_o=1 and ready_i=0.
// Revision    : 1.0  initial release
// ============================================================================
module sram_fifo_fwft_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]          fifo_data_i,
    output logic                           fifo_pop_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy_o
`ifdef SRAM_FWFT_STALL_CNT_EN
    ,
    output logic [31:0]                    stall_cnt_o
`endif
);

    localparam int c_OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int c_PTR_W = $clog2(BUF_DEPTH);
    localparam int c_SUM_W = c_OCC_W + 2;

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
            $error("sram_fifo_fwft_adapter: RD_LATENCY must be 1 or 2");
        end
        if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
            $error("sram_fifo_fwft_adapter: BUF_DEPTH must be >= RD_LATENCY+1");
        end
    endgenerate

    logic [RD_LATENCY-1:0]   r_tag;
    logic [c_OCC_W-1:0]      r_occ;
    logic [c_PTR_W-1:0]      r_head;
    logic [c_PTR_W-1:0]      r_tail;
    logic [DATA_WIDTH-1:0]   r_mem [BUF_DEPTH];

    logic                    w_acc;
    logic                    w_cap;
    logic                    w_pop;
    logic [c_SUM_W-1:0]      w_inflight;
    logic [c_SUM_W-1:0]      w_pending;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Count pops whose data has not yet returned from the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + c_SUM_W'(r_tag[i]);
        end
    end

    // Credit check: buffered + in-flight words after this edge must fit.
    always_comb begin
        w_acc     = valid_o && ready_i;
        w_cap     = r_tag[RD_LATENCY-1];
        w_pending = c_SUM_W'(r_occ) + w_inflight - c_SUM_W'(w_acc);
        w_pop     = !fifo_empty_i && !flush_i && !rst_i &&
                    (w_pending < c_SUM_W'(BUF_DEPTH));
    end

    // Tag pipe, pointers and occupancy; flush squashes everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_tag  <= '0;
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_tag <= (r_tag << 1) | RD_LATENCY'(w_pop);
            if (w_cap) begin
                r_tail <= f_next(r_tail);
            end
            if (w_acc) begin
                r_head <= f_next(r_head);
            end
            case ({w_cap, w_acc})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Buffer storage; cleared on reset so data_o reads zero afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_cap && !flush_i) begin
            r_mem[r_tail] <= fifo_data_i;
        end
    end

    assign fifo_pop_o  = w_pop;
    assign valid_o     = (r_occ != '0);
    assign data_o      = r_mem[r_head];
    assign occupancy_o = r_occ;

`ifdef SRAM_FWFT_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles the consumer holds off a valid word.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_stall_cnt <= '0;
        end else if (valid_o && !ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_fwft_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_fifo_fwft_adapter
// Description : Bench for sram_fifo_fwft_adapter. Config 0 uses RD_LATENCY=1,
//               BUF_DEPTH=2; config 1 uses RD_LATENCY=2, BUF_DEPTH=3. Each
//               config has its own FIFO model and a word-level reference
//               (pop log with timestamps) checked every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_fifo_fwft_adapter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    flush;
    logic [1:0]    ready;
    logic [1:0]    empty;
    logic [1:0]    pop;
    logic [1:0]    valid;
    logic [DW-1:0] fdata [2];
    logic [DW-1:0] data  [2];
    logic [1:0]    occ   [2];
`ifdef SRAM_FWFT_STALL_CNT_EN
    logic [31:0]   stall [2];
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- FIFO models (stimulus side) ----------------
    logic [DW-1:0] fmem [2][0:127];
    int            frd  [2];
    int            fwr  [2];
    logic [DW-1:0] p1a;

    assign empty[0] = (frd[0] == fwr[0]);
    assign empty[1] = (frd[1] == fwr[1]);

    // Read data returns 1 cycle (cfg0) or 2 cycles (cfg1) after the pop.
    always @(posedge clk) begin
        fdata[0] <= (pop[0] && !empty[0]) ? fmem[0][frd[0]] : 32'hDEAD_0000;
        p1a      <= (pop[1] && !empty[1]) ? fmem[1][frd[1]] : 32'hDEAD_0001;
        fdata[1] <= p1a;
        for (int k = 0; k < 2; k++) begin
            if (rst || flush[k])          frd[k] <= fwr[k];
            else if (pop[k] && !empty[k]) frd[k] <= frd[k] + 1;
        end
    end

    // ---------------- DUTs ----------------
    sram_fifo_fwft_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(1), .BUF_DEPTH(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[0]), .fifo_empty_i(empty[0]),
        .fifo_data_i(fdata[0]), .fifo_pop_o(pop[0]), .valid_o(valid[0]),
        .ready_i(ready[0]), .data_o(data[0]), .occupancy_o(occ[0])
`ifdef SRAM_FWFT_STALL_CNT_EN
        , .stall_cnt_o(stall[0])
`endif
    );

    sram_fifo_fwft_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(2), .BUF_DEPTH(3)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush[1]), .fifo_empty_i(empty[1]),
        .fifo_data_i(fdata[1]), .fifo_pop_o(pop[1]), .valid_o(valid[1]),
        .ready_i(ready[1]), .data_o(data[1]), .occupancy_o(occ[1])
`ifdef SRAM_FWFT_STALL_CNT_EN
        , .stall_cnt_o(stall[1])
`endif
    );

    // ---------------- reference model state ----------------
    int            np  [2];          // pops so far
    int            hd  [2];          // next word index to deliver
    logic [DW-1:0] pw  [2][0:127];   // popped word
    int            pt  [2][0:127];   // cycle of pop
    int            ng  [2];          // words accepted from DUT
    logic [DW-1:0] got [2][0:127];
    int            gc  [2][0:127];
    int            maxocc [2];
    int            est [2];          // expected stall count
    int            nerr = 0;
    int            nchk = 0;
    bit            armed = 1'b0;

    task automatic chk(input string nm, input int k, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cfg%0d cyc=%0d got=%h expected=%h", nm, k, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the word-level model, then advance the model.
    // A popped word sits in the buffer from pop cycle + RD_LATENCY + 1 on.
    task automatic compare_cycle();
        for (int k = 0; k < 2; k++) begin
            int land;
            int pend;
            bit ev;
            bit eacc;
            bit epop;
            land = 0;
            for (int i = hd[k]; i < np[k]; i++) begin
                if (cyc >= pt[k][i] + k + 2) land++;
            end
            pend = np[k] - hd[k];
            ev   = (land != 0);
            eacc = ev && ready[k];
            epop = !empty[k] && !flush[k] && !rst && ((pend - int'(eacc)) < k + 2);
            if (armed) begin
                chk("fifo_pop_o", k, DW'(pop[k]), DW'(epop));
                chk("valid_o", k, DW'(valid[k]), DW'(ev));
                chk("occupancy_o", k, DW'(occ[k]), DW'(land));
                if (ev) chk("data_o", k, data[k], pw[k][hd[k]]);
`ifdef SRAM_FWFT_STALL_CNT_EN
                chk("stall_cnt_o", k, stall[k], DW'(est[k]));
`endif
            end
            if (int'(occ[k]) > maxocc[k]) maxocc[k] = int'(occ[k]);
            if (valid[k] && ready[k] && ng[k] < 128) begin
                got[k][ng[k]] = data[k];
                gc[k][ng[k]]  = cyc;
                ng[k]++;
            end
            if (rst || flush[k]) est[k] = 0;
            else if (ev && !ready[k]) est[k]++;
            if (rst || flush[k]) begin
                hd[k] = np[k];
            end else begin
                if (eacc) hd[k]++;
                if (pop[k] && !empty[k] && np[k] < 128) begin
                    pw[k][np[k]] = fmem[k][frd[k]];
                    pt[k][np[k]] = cyc;
                    np[k]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fmem[k][fwr[k] + i] = base + DW'(i);
        fwr[k] = fwr[k] + n;
    endtask

    // Checks n words from index g0 are base, base+1, ...; optionally gap-free.
    task automatic chk_seq(input int k, input int g0, input logic [DW-1:0] base,
                           input int n, input bit nogap);
        chk("word count", k, DW'(ng[k] - g0), DW'(n));
        for (int i = 0; i < n; i++) chk("word order", k, got[k][g0 + i], base + DW'(i));
        if (nogap) chk("no gaps", k, DW'(gc[k][g0 + n - 1] - gc[k][g0]), DW'(n - 1));
    endtask

    initial begin
        int t0;
        int p0;
        int g0;
        int n;
        rst = 1'b1; flush = 2'b00; ready = 2'b00;
        step();
        step();
        rst = 1'b0;
        armed = 1'b1;

        // Reset state
        for (int k = 0; k < 2; k++) begin
            chk("reset valid_o", k, DW'(valid[k]), 32'd0);
            chk("reset occupancy_o", k, DW'(occ[k]), 32'd0);
            chk("reset data_o", k, data[k], 32'd0);
        end

        // Idle with empty FIFOs
        repeat (10) step();
        chk("idle pops", 0, DW'(np[0] + np[1]), 32'd0);

        // cfg0 stream A0..A7 with ready=1
        ready[0] = 1'b1; p0 = np[0]; g0 = ng[0];
        load(0, 32'hA0, 8);
        t0 = cyc;
        n = 0;
        while (!valid[0] && n < 10) begin step(); n++; end
        chk("first valid latency", 0, DW'(cyc - t0), 32'd2);
        repeat (12) step();
        chk("stream pops", 0, DW'(np[0] - p0), 32'd8);
        chk_seq(0, g0, 32'hA0, 8, 1'b1);

        // cfg0 backpressure then release
        ready[0] = 1'b0; p0 = np[0]; g0 = ng[0];
        load(0, 32'hA0, 8);
        repeat (20) step();
        chk("backpressure pops", 0, DW'(np[0] - p0), 32'd2);
        chk("backpressure occupancy", 0, DW'(occ[0]), 32'd2);
        chk("backpressure data", 0, data[0], 32'hA0);
        chk("backpressure valid", 0, DW'(valid[0]), 32'd1);
        ready[0] = 1'b1;
        repeat (15) step();
        chk_seq(0, g0, 32'hA0, 8, 1'b1);
        ready[0] = 1'b0;

        // cfg1 toggling ready, 16 words
        maxocc[1] = 0; g0 = ng[1];
        load(1, 32'hB0, 16);
        for (int i = 0; i < 50; i++) begin
            ready[1] = (i % 2 == 0);
            step();
        end
        ready[1] = 1'b0;
        chk_seq(1, g0, 32'hB0, 16, 1'b0);
        chk("max occupancy within 3", 1, DW'(maxocc[1] <= 3), 32'd1);

        // cfg0 flush with words buffered and one in flight
        g0 = ng[0];
        load(0, 32'hC0, 4);
        repeat (4) step();
        chk("pre-flush occupancy", 0, DW'(occ[0]), 32'd2);
        ready[0] = 1'b1;
        step();
        ready[0] = 1'b0; flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        chk("post-flush valid", 0, DW'(valid[0]), 32'd0);
        chk("post-flush occupancy", 0, DW'(occ[0]), 32'd0);
        ready[0] = 1'b1;
        repeat (6) step();
        ready[0] = 1'b0;
        chk("flush delivered count", 0, DW'(ng[0] - g0), 32'd1);
        chk("flush delivered word", 0, got[0][g0], 32'hC0);

        // Reset mid-operation
        g0 = ng[0];
        load(0, 32'hD0, 4);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post-reset data_o", 0, data[0], 32'd0);
        chk("post-reset valid", 0, DW'(valid[0]), 32'd0);
        chk("post-reset occupancy", 0, DW'(occ[0]), 32'd0);
        ready[0] = 1'b1;
        repeat (5) step();
        ready[0] = 1'b0;
        chk("post-reset delivered", 0, DW'(ng[0] - g0), 32'd0);

`ifdef SRAM_FWFT_STALL_CNT_EN
        // Stall counter: 5 stalled cycles, then flush clears it
        load(0, 32'hE0, 2);
        n = 0;
        while (!valid[0] && n < 10) begin step(); n++; end
        repeat (5) step();
        chk("stall count after 5", 0, stall[0], 32'd5);
        flush[0] = 1'b1;
        step();
        flush[0] = 1'b0;
        chk("stall count after flush", 0, stall[0], 32'd0);
`endif

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
